aui_lane_distributor: RTL
=========================

Name: aui_lane_distributor

Overview:
Parametrised multi-lane AUI transmit source and successor to the broadcast-only lane generator. It takes a valid/ready word stream and drives NUMBER_LANES registered lanes in one of three modes: broadcast, round-robin distribution, or per-lane PRBS31 test pattern. Alignment markers can optionally be inserted periodically in the data modes. It sits between the upstream data/test source and the per-lane serialiser models.

Parameters:
DATA_WIDTH, 64, bits per lane word; integer multiple of 8, at least 32
NUMBER_LANES, 16, number of output lanes; range 1..256
AM_PERIOD, 1024, data beats between alignment markers; at least 2

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active low
i_mode  input  2  0=broadcast, 1=distribute, 2=PRBS31, 3=idle
i_data  input  DATA_WIDTH  input word
i_valid  input  1  input word valid
o_ready  output  1  input accept; transfer occurs when i_valid && o_ready
tx_lane  output  [NUMBER_LANES-1:0][DATA_WIDTH]  lane words, registered
o_lane_valid  output  1  tx_lane holds a new beat this cycle
o_am  output  1  current beat is an alignment marker

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: tx_lane all 0, o_lane_valid 0, o_am 0, mode_q 0, fill_idx 0, beat_cnt 0, am_due 0.
- PRBS lane i state at reset = i+1, as a 31-bit value.
- Mode register: mode_q <= i_mode every cycle; all behaviour uses mode_q.
- Mode change: on a cycle where mode_q changes value, the following happen at that edge:
  - fill_idx, beat_cnt and am_due clear.
  - PRBS states reseed to i+1.
  - Any partial distribute group is discarded.
  - No beat is emitted that cycle.
- o_ready (combinational) = (mode_q==0 || mode_q==1) && !am_due.
- Mode 0 (broadcast): an accepted word appears on every lane next cycle with o_lane_valid=1. Latency 1, full throughput.
- Mode 1 (distribute):
  - Accepted word k (k = fill_idx) is stored in staging[k]; fill_idx increments and wraps from NUMBER_LANES-1 to 0.
  - Acceptance at fill_idx==NUMBER_LANES-1: next cycle tx_lane[j] = staging[j] for all j (the last word bypasses staging), with o_lane_valid=1 for one cycle.
  - The other words of the group produce no beat.
- Mode 2 (PRBS31):
  - Polynomial x^31+x^28+1, Fibonacci form: new bit = s[30]^s[27], state shifts left inserting the new bit.
  - Each cycle every lane advances DATA_WIDTH steps. The first generated bit is placed in tx_lane bit DATA_WIDTH-1, continuing down to bit 0.
  - o_lane_valid=1 every cycle, o_ready=0, i_data ignored.
- Mode 3 (idle): o_ready=0, o_lane_valid=0.
- Non-beat cycles: o_lane_valid=0, o_am=0, tx_lane holds its last value.
- Beat counting (modes 0/1): beat_cnt increments on each emitted data beat. When an emitted data beat brings it to AM_PERIOD, am_due<=1.
- Marker emission: in a cycle with am_due=1 the marker is emitted next edge. beat_cnt<=0 and am_due<=0. Zero gap after the AM_PERIOD-th data beat.
- Input during marker: o_ready=0 while am_due=1, so no input is accepted; the distribute partial group and fill_idx are preserved.
- Marker content: tx_lane[i] = {(DATA_WIDTH-8)/8 bytes of 8'hA5, i[7:0]}, with o_lane_valid=1 and o_am=1.
- Reset mid-operation: all state returns to reset values immediately; the partial group is lost.

Optional Feature:
AUI_AM_INSERT_EN:
- Defined: alignment marker insertion as described above.
- Undefined: beat_cnt and am_due are not implemented, o_am is tied 0, and o_ready = (mode_q==0 || mode_q==1).

Test Plan:
- Broadcast: mode 0, one word 64'h1122334455667788 -> next cycle all 16 lanes equal it, o_lane_valid high exactly one cycle.
- Distribute: mode 1, words 0..15 back-to-back -> no valid for words 0..14; cycle after word 15, tx_lane[i]==i and o_lane_valid high one cycle; throughput of 16 words sustained without bubbles.
- AM (AUI_AM_INSERT_EN, AM_PERIOD=4, mode 0, i_valid stuck high):
  - 4 data beats, then o_ready low 1 cycle.
  - Marker beat has o_am=1, tx_lane[3]==64'hA5A5A5A5A5A5A503.
  - Data resumes with no lost or duplicated words.
- PRBS: mode 2 -> o_ready=0, o_lane_valid=1 every cycle; lane 0 and lane 5 first words match the model seeded 1 and 6; lanes pairwise differ.
- Mode change: mode 1, accept 7 words; switch to mode 0 and back to 1; send 16 words -> the emitted group equals exactly those 16 words in order, with no stale entries.
- Reset: rst_n low mid-group in mode 1 -> outputs 0 immediately (asynchronously); after release, the first 16 words form a group starting at lane 0.

Source files
------------

// File: rtl/aui_lane_distributor.sv
// ---------------------------------------------------------------------------
// aui_lane_distributor
// Multi-lane AUI transmit source. Takes a valid/ready word stream and drives
// NUMBER_LANES registered lanes in one of four modes selected by i_mode
// (registered internally as mode_r):
//   0 = broadcast   : every accepted word goes to all lanes next cycle
//   1 = distribute  : NUMBER_LANES accepted words form one beat, word k on lane k
//   2 = PRBS31      : each lane runs its own x^31+x^28+1 generator
//   3 = idle        : no beats, no input accepted
// Optional feature macro AUI_AM_INSERT_EN: when defined, an alignment marker
// beat is inserted after every AM_PERIOD data beats in modes 0/1. When not
// defined, o_am is tied low and no marker logic is built.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   i_mode [1:0]  mode select
//   i_data        input word, i_valid qualifies it
//   o_ready       input accept (transfer on i_valid && o_ready)
//   tx_lane       registered lane words, [NUMBER_LANES-1:0][DATA_WIDTH-1:0]
//   o_lane_valid  tx_lane carries a new beat this cycle
//   o_am          current beat is an alignment marker
// ---------------------------------------------------------------------------
module aui_lane_distributor #(
  parameter int DATA_WIDTH   = 64,
  parameter int NUMBER_LANES = 16,
  parameter int AM_PERIOD    = 1024
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [1:0]                                i_mode,
  input  logic [DATA_WIDTH-1:0]                     i_data,
  input  logic                                      i_valid,
  output logic                                      o_ready,
  output logic [NUMBER_LANES-1:0][DATA_WIDTH-1:0]   tx_lane,
  output logic                                      o_lane_valid,
  output logic                                      o_am
);

  localparam int IDX_W = (NUMBER_LANES > 1) ? $clog2(NUMBER_LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBER_LANES - 1);

  // Elaboration-time parameter sanity checks
  if ((DATA_WIDTH < 32) || ((DATA_WIDTH % 8) != 0) ||
      (NUMBER_LANES < 1) || (NUMBER_LANES > 256) || (AM_PERIOD < 2)) begin : g_bad_params
    $error("aui_lane_distributor: illegal parameter combination");
  end

  // Advance one PRBS31 lane by DATA_WIDTH steps; returns {next_state, word}.
  // First generated bit lands in the word MSB.
  function automatic logic [DATA_WIDTH+30:0] prbs_advance(input logic [30:0] seed);
    logic [30:0]           s;
    logic [DATA_WIDTH-1:0] w;
    logic                  nb;
    s = seed;
    w = '0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      nb = s[30] ^ s[27];
      w[DATA_WIDTH-1-k] = nb;
      s = {s[29:0], nb};
    end
    return {s, w};
  endfunction

  logic [1:0]                                mode_r;
  logic [IDX_W-1:0]                          fill_idx_r;
  logic [NUMBER_LANES-1:0][DATA_WIDTH-1:0]   staging_r;
  logic [NUMBER_LANES-1:0][DATA_WIDTH-1:0]   tx_lane_r;
  logic                                      lane_valid_r;
  logic [NUMBER_LANES-1:0][30:0]             prbs_r;
  logic [NUMBER_LANES-1:0][30:0]             prbs_nxt_s;
  logic [NUMBER_LANES-1:0][DATA_WIDTH-1:0]   prbs_word_s;
  logic                                      mode_chg_s;
  logic                                      data_mode_s;
  logic                                      accept_s;
  logic                                      emit_data_s;
  logic                                      am_block_s;

  assign tx_lane      = tx_lane_r;
  assign o_lane_valid = lane_valid_r;

  // Mode-change detect and handshake. A word accepted on a mode-change edge
  // is dropped together with any partial group.
  always_comb begin
    mode_chg_s  = (i_mode != mode_r);
    data_mode_s = (mode_r == 2'd0) || (mode_r == 2'd1);
    o_ready     = data_mode_s && !am_block_s;
    accept_s    = i_valid && o_ready && !mode_chg_s;
    emit_data_s = accept_s && ((mode_r == 2'd0) || (fill_idx_r == LAST_IDX));
  end

  // Per-lane PRBS next state and output word
  always_comb begin
    prbs_nxt_s  = '0;
    prbs_word_s = '0;
    for (int i = 0; i < NUMBER_LANES; i++) begin
      {prbs_nxt_s[i], prbs_word_s[i]} = prbs_advance(prbs_r[i]);
    end
  end

  // Mode register, distribute fill index and staging buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r     <= 2'd0;
      fill_idx_r <= '0;
      staging_r  <= '0;
    end else begin
      mode_r <= i_mode;
      if (mode_chg_s) begin
        fill_idx_r <= '0;
      end else if (accept_s && (mode_r == 2'd1)) begin
        staging_r[fill_idx_r] <= i_data;
        fill_idx_r <= (fill_idx_r == LAST_IDX) ? '0 : fill_idx_r + IDX_W'(1);
      end else begin
        fill_idx_r <= fill_idx_r;
      end
    end
  end

  // PRBS lane generators: reseed to lane+1 on reset and on mode change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUMBER_LANES; i++) prbs_r[i] <= 31'(i + 1);
    end else if (mode_chg_s) begin
      for (int i = 0; i < NUMBER_LANES; i++) prbs_r[i] <= 31'(i + 1);
    end else if (mode_r == 2'd2) begin
      prbs_r <= prbs_nxt_s;
    end else begin
      prbs_r <= prbs_r;
    end
  end

`ifdef AUI_AM_INSERT_EN
  localparam int CNT_W = $clog2(AM_PERIOD + 1);

  // Marker word for one lane: 0xA5 filler bytes, lane number in the low byte
  function automatic logic [DATA_WIDTH-1:0] am_marker(input int lane);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    for (int b = 1; b < DATA_WIDTH / 8; b++) w[b*8 +: 8] = 8'hA5;
    w[7:0] = 8'(lane);
    return w;
  endfunction

  logic [CNT_W-1:0]                          beat_cnt_r;
  logic                                      am_due_r;
  logic                                      am_r;
  logic                                      am_emit_s;
  logic [NUMBER_LANES-1:0][DATA_WIDTH-1:0]   am_word_s;

  assign am_block_s = am_due_r;
  assign o_am       = am_r;

  // Marker emission qualifier and constant marker words
  always_comb begin
    am_emit_s = am_due_r && !mode_chg_s;
    am_word_s = '0;
    for (int i = 0; i < NUMBER_LANES; i++) am_word_s[i] = am_marker(i);
  end

  // Data beat counter and marker-due flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_r <= '0;
      am_due_r   <= 1'b0;
    end else if (mode_chg_s || am_emit_s) begin
      beat_cnt_r <= '0;
      am_due_r   <= 1'b0;
    end else if (emit_data_s) begin
      beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      am_due_r   <= ((beat_cnt_r + CNT_W'(1)) == CNT_W'(AM_PERIOD));
    end else begin
      beat_cnt_r <= beat_cnt_r;
      am_due_r   <= am_due_r;
    end
  end

  // Marker flag output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am_r <= 1'b0;
    end else begin
      am_r <= am_emit_s;
    end
  end
`else
  assign am_block_s = 1'b0;
  assign o_am       = 1'b0;
`endif

  // Lane output registers: marker, data beat, PRBS, or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_lane_r    <= '0;
      lane_valid_r <= 1'b0;
    end else begin
      lane_valid_r <= 1'b0;
      if (mode_chg_s) begin
        tx_lane_r <= tx_lane_r;
`ifdef AUI_AM_INSERT_EN
      end else if (am_emit_s) begin
        tx_lane_r    <= am_word_s;
        lane_valid_r <= 1'b1;
`endif
      end else if (emit_data_s) begin
        // Broadcast copies i_data everywhere; distribute bypasses the last word
        for (int j = 0; j < NUMBER_LANES; j++) begin
          tx_lane_r[j] <= ((mode_r == 2'd0) || (j == NUMBER_LANES - 1)) ? i_data : staging_r[j];
        end
        lane_valid_r <= 1'b1;
      end else if (mode_r == 2'd2) begin
        tx_lane_r    <= prbs_word_s;
        lane_valid_r <= 1'b1;
      end else begin
        tx_lane_r <= tx_lane_r;
      end
    end
  end

endmodule
